// File: rtl/osd_scm_ctrl_if.sv
// Status/control register access bus between the debug module and a subnet control block.
interface osd_scm_ctrl_if;
   logic        reg_request;
   logic        reg_write;
   logic [15:0] reg_addr;
   logic        reg_size;
   logic [15:0] reg_wdata;
   logic        reg_ack;
   logic        reg_err;
   logic [15:0] reg_rdata;

   modport master (
      output reg_request, reg_write, reg_addr, reg_size, reg_wdata,
      input  reg_ack, reg_err, reg_rdata
   );

   modport slave (
      input  reg_request, reg_write, reg_addr, reg_size, reg_wdata,
      output reg_ack, reg_err, reg_rdata
   );
endinterface

// File: rtl/osd_scm_ctrl.sv
// Subnet control module: system ID registers, held/pulsed domain resets and CPU stall.
module osd_scm_ctrl #(
   parameter logic [15:0] SYSTEM_VENDOR   = 16'h0,
   parameter logic [15:0] SYSTEM_DEVICE   = 16'h0,
   parameter int unsigned NUM_MOD         = 0,
   parameter int unsigned MAX_PKT_LEN     = 0,
   parameter int unsigned NUM_RST_DOMAINS = 2,
   parameter int unsigned RST_PULSE_LEN   = 16,
   parameter bit          CPU_STALL_INIT  = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   osd_scm_ctrl_if.slave              bus,
   output logic [NUM_RST_DOMAINS-1:0] sys_rst,
   output logic                       cpu_stall,
   output logic                       rst_busy
);

   localparam int unsigned ND       = NUM_RST_DOMAINS;
   localparam logic [15:0] DOM_MASK = 16'((32'd1 << ND) - 32'd1);
   localparam logic [15:0] PLEN     = 16'(RST_PULSE_LEN);

   typedef enum logic {IDLE, RESP} state_t;

   state_t          state, state_nxt;
   logic            ack_nxt, err_nxt;
   logic [15:0]     rdata_nxt;
   logic [ND-1:0]   hold_mask, hold_nxt;
   logic [ND-1:0]   pulse_mask, pulse_nxt;
   logic [15:0]     count, count_nxt, count_dec;
   logic            stall_nxt;
   logic [15:0]     wdata_trim;

   // Free-running pulse countdown and write data cut down to the implemented domains
   assign count_dec  = (count != 16'd0) ? count - 16'd1 : 16'd0;
   assign wdata_trim = bus.reg_wdata & DOM_MASK;

   // State register and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         bus.reg_ack   <= 1'b0;
         bus.reg_err   <= 1'b0;
         bus.reg_rdata <= 16'd0;
         hold_mask     <= '0;
         pulse_mask    <= '0;
         count         <= 16'd0;
         rst_busy      <= 1'b0;
         sys_rst       <= '0;
         cpu_stall     <= CPU_STALL_INIT;
      end else begin
         state         <= state_nxt;
         bus.reg_ack   <= ack_nxt;
         bus.reg_err   <= err_nxt;
         bus.reg_rdata <= rdata_nxt;
         hold_mask     <= hold_nxt;
         pulse_mask    <= pulse_nxt;
         count         <= count_nxt;
         rst_busy      <= (count_nxt != 16'd0);
         sys_rst       <= hold_nxt | (pulse_nxt & {ND{count_nxt != 16'd0}});
         cpu_stall     <= stall_nxt;
      end
   end

   // Access decode: next state, response and register updates
   always_comb begin
      state_nxt = state;
      ack_nxt   = 1'b0;
      err_nxt   = 1'b0;
      rdata_nxt = 16'd0;
      hold_nxt  = hold_mask;
      pulse_nxt = pulse_mask;
      count_nxt = count_dec;
      stall_nxt = cpu_stall;

      case (state)
         IDLE: begin
            if (bus.reg_request) begin
               state_nxt = RESP;
               ack_nxt   = 1'b1;
               if (bus.reg_size) begin
                  err_nxt = 1'b1;
               end else begin
                  case (bus.reg_addr)
                     16'h0200: if (bus.reg_write) err_nxt = 1'b1;
                               else rdata_nxt = SYSTEM_VENDOR;
                     16'h0201: if (bus.reg_write) err_nxt = 1'b1;
                               else rdata_nxt = SYSTEM_DEVICE;
                     16'h0202: if (bus.reg_write) err_nxt = 1'b1;
                               else rdata_nxt = 16'(NUM_MOD);
                     16'h0203: if (bus.reg_write) err_nxt = 1'b1;
                               else rdata_nxt = 16'(MAX_PKT_LEN);
                     16'h0204: if (bus.reg_write) hold_nxt = wdata_trim[ND-1:0];
                               else rdata_nxt = 16'(hold_mask);
                     16'h0205: begin
                        if (!bus.reg_write) begin
                           // count as it stands in the ack cycle
                           rdata_nxt = count_dec;
                        end else if (rst_busy) begin
                           err_nxt = 1'b1;
                        end else if (wdata_trim != 16'd0) begin
                           pulse_nxt = wdata_trim[ND-1:0];
                           count_nxt = PLEN;
                        end
                     end
                     16'h0206: if (bus.reg_write) stall_nxt = bus.reg_wdata[0];
                               else rdata_nxt = {15'd0, cpu_stall};
                     16'h0207: if (bus.reg_write) err_nxt = 1'b1;
                               else rdata_nxt = {8'(ND), 7'd0, (count_dec != 16'd0)};
                     default:  err_nxt = 1'b1;
                  endcase
               end
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_osd_scm_ctrl.sv
// Self-checking bench for osd_scm_ctrl: directed table, pulse/reset sequences, random traffic.
module tb_osd_scm_ctrl;

   localparam int ND  = 2;
   localparam int LEN = 4;

   logic          clk;
   logic          rst;
   logic [ND-1:0] sys_rst;
   logic          cpu_stall;
   logic          rst_busy;

   osd_scm_ctrl_if bus ();

   osd_scm_ctrl #(
      .SYSTEM_VENDOR  (16'h1234),
      .SYSTEM_DEVICE  (16'h0042),
      .NUM_MOD        (5),
      .MAX_PKT_LEN    (12),
      .NUM_RST_DOMAINS(ND),
      .RST_PULSE_LEN  (LEN),
      .CPU_STALL_INIT (1'b0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .sys_rst  (sys_rst),
      .cpu_stall(cpu_stall),
      .rst_busy (rst_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: pulse described by its launch cycle, not by a counter
   int m_hold   = 0;
   bit m_stall  = 1'b0;
   int m_pmask  = 0;
   int m_pstart = -1000;

   function automatic int m_count(input int c);
      if (c >= m_pstart + 1 && c <= m_pstart + LEN) return m_pstart + LEN - c + 1;
      return 0;
   endfunction

   function automatic bit m_busy(input int c);
      return m_count(c) != 0;
   endfunction

   task automatic model_reset();
      m_hold   = 0;
      m_stall  = 1'b0;
      m_pmask  = 0;
      m_pstart = -1000;
   endtask

   // Expected response for an access whose request is sampled in cycle n
   task automatic model_access(input bit w, input logic [15:0] a, input bit sz,
                               input logic [15:0] d, input int n,
                               output bit xe, output logic [15:0] xr);
      xe = 1'b0;
      xr = 16'd0;
      if (sz || a < 16'h0200 || a > 16'h0207) xe = 1'b1;
      else if (w) begin
         case (a)
            16'h0204: m_hold = int'(d) & 3;
            16'h0205: begin
               if (m_busy(n)) xe = 1'b1;
               else if ((int'(d) & 3) != 0) begin
                  m_pmask  = int'(d) & 3;
                  m_pstart = n;
               end
            end
            16'h0206: m_stall = d[0];
            default:  xe = 1'b1;
         endcase
      end else begin
         case (a)
            16'h0200: xr = 16'h1234;
            16'h0201: xr = 16'h0042;
            16'h0202: xr = 16'd5;
            16'h0203: xr = 16'd12;
            16'h0204: xr = 16'(m_hold);
            16'h0205: xr = 16'(m_count(n + 1));
            16'h0206: xr = {15'd0, m_stall};
            default:  xr = {8'(ND), 7'd0, m_busy(n + 1)};
         endcase
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @cyc%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic chk_outs();
      int exp_rst;
      exp_rst = m_hold | (m_busy(cyc) ? m_pmask : 0);
      chk("sys_rst", 32'(sys_rst), 32'(exp_rst));
      chk("rst_busy", 32'(rst_busy), 32'(m_busy(cyc)));
      chk("cpu_stall", 32'(cpu_stall), 32'(m_stall));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         chk("idle_ack", 32'(bus.reg_ack), 32'd0);
         chk("idle_rdata", 32'(bus.reg_rdata), 32'd0);
         chk_outs();
      end
   endtask

   // One full access: request cycle n, ack cycle n+1, back in IDLE at n+2
   task automatic access(input bit w, input logic [15:0] a, input bit sz,
                         input logic [15:0] d, output bit e, output logic [15:0] r);
      bit          xe;
      logic [15:0] xr;
      model_access(w, a, sz, d, cyc, xe, xr);
      bus.reg_request = 1'b1;
      bus.reg_write   = w;
      bus.reg_addr    = a;
      bus.reg_size    = sz;
      bus.reg_wdata   = d;
      tick();
      chk("ack", 32'(bus.reg_ack), 32'd1);
      chk("err", 32'(bus.reg_err), 32'(xe));
      chk("rdata", 32'(bus.reg_rdata), 32'(xr));
      chk_outs();
      e = bus.reg_err;
      r = bus.reg_rdata;
      bus.reg_request = 1'b0;
      bus.reg_write   = 1'b0;
      tick();
      chk("ack_drop", 32'(bus.reg_ack), 32'd0);
      chk("rdata_drop", 32'(bus.reg_rdata), 32'd0);
      chk_outs();
   endtask

   typedef struct {
      bit          w;
      logic [15:0] a;
      bit          sz;
      logic [15:0] d;
      bit          xe;
      logic [15:0] xr;
   } vec_t;

   vec_t tbl[14];

   initial begin
      bit          e;
      logic [15:0] r;
      int          n;

      tbl[0]  = '{1'b0, 16'h0200, 1'b0, 16'h0000, 1'b0, 16'h1234};
      tbl[1]  = '{1'b0, 16'h0201, 1'b0, 16'h0000, 1'b0, 16'h0042};
      tbl[2]  = '{1'b0, 16'h0202, 1'b0, 16'h0000, 1'b0, 16'h0005};
      tbl[3]  = '{1'b0, 16'h0203, 1'b0, 16'h0000, 1'b0, 16'h000C};
      tbl[4]  = '{1'b0, 16'h01FF, 1'b0, 16'h0000, 1'b1, 16'h0000};
      tbl[5]  = '{1'b1, 16'h0200, 1'b0, 16'h0000, 1'b1, 16'h0000};
      tbl[6]  = '{1'b0, 16'h0200, 1'b0, 16'h0000, 1'b0, 16'h1234};
      tbl[7]  = '{1'b0, 16'h0200, 1'b1, 16'h0000, 1'b1, 16'h0000};
      tbl[8]  = '{1'b1, 16'h0204, 1'b0, 16'hFFFF, 1'b0, 16'h0000};
      tbl[9]  = '{1'b0, 16'h0204, 1'b0, 16'h0000, 1'b0, 16'h0003};
      tbl[10] = '{1'b1, 16'h0204, 1'b0, 16'h0000, 1'b0, 16'h0000};
      tbl[11] = '{1'b0, 16'h0204, 1'b0, 16'h0000, 1'b0, 16'h0000};
      tbl[12] = '{1'b0, 16'h0207, 1'b0, 16'h0000, 1'b0, 16'h0200};
      tbl[13] = '{1'b0, 16'h0208, 1'b0, 16'h0000, 1'b1, 16'h0000};

      rst             = 1'b1;
      bus.reg_request = 1'b0;
      bus.reg_write   = 1'b0;
      bus.reg_addr    = 16'd0;
      bus.reg_size    = 1'b0;
      bus.reg_wdata   = 16'd0;
      tick();
      tick();
      chk("rst_ack", 32'(bus.reg_ack), 32'd0);
      chk("rst_err", 32'(bus.reg_err), 32'd0);
      chk("rst_rdata", 32'(bus.reg_rdata), 32'd0);
      chk_outs();
      rst = 1'b0;
      idle(2);

      // Directed register table
      for (int i = 0; i < 14; i++) begin
         access(tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].d, e, r);
         chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].xe));
         chk($sformatf("tbl%0d_rdata", i), 32'(r), 32'(tbl[i].xr));
      end

      // Held mask applied from the ack cycle
      access(1'b1, 16'h0204, 1'b0, 16'hFFFF, e, r);
      chk("hold_all", 32'(sys_rst), 32'd3);
      access(1'b1, 16'h0204, 1'b0, 16'h0000, e, r);
      chk("hold_none", 32'(sys_rst), 32'd0);

      // Pulse window N+1..N+LEN, rejected relaunch at N+2
      n = cyc;
      access(1'b1, 16'h0205, 1'b0, 16'h0002, e, r);
      chk("pulse_err", 32'(e), 32'd0);
      access(1'b1, 16'h0205, 1'b0, 16'h0003, e, r);
      chk("relaunch_err", 32'(e), 32'd1);
      for (int k = 5; k <= 7; k++) begin
         tick();
         chk($sformatf("pulse_rst_k%0d", k), 32'(sys_rst), 32'd0);
         chk($sformatf("pulse_busy_k%0d", k), 32'(rst_busy), 32'd0);
      end
      chk("pulse_len", 32'(cyc - n), 32'd7);

      // Count readback two cycles into a pulse
      access(1'b1, 16'h0205, 1'b0, 16'h0002, e, r);
      access(1'b0, 16'h0205, 1'b0, 16'h0000, e, r);
      chk("count_read", 32'(r), 32'd2);
      idle(3);

      // Zero-mask pulse is accepted but launches nothing
      access(1'b1, 16'h0205, 1'b0, 16'hFFFC, e, r);
      chk("zero_pulse_err", 32'(e), 32'd0);
      chk("zero_pulse_busy", 32'(rst_busy), 32'd0);

      // Stall, then status during a pulse
      access(1'b1, 16'h0206, 1'b0, 16'h0001, e, r);
      chk("stall_set", 32'(cpu_stall), 32'd1);
      access(1'b1, 16'h0205, 1'b0, 16'h0002, e, r);
      access(1'b0, 16'h0207, 1'b0, 16'h0000, e, r);
      chk("status_busy", 32'(r), 32'h0201);
      idle(3);

      // Held mask written mid-pulse ORs with the pulse
      access(1'b1, 16'h0205, 1'b0, 16'h0002, e, r);
      model_access(1'b1, 16'h0204, 1'b0, 16'h0001, cyc, e, r);
      bus.reg_request = 1'b1;
      bus.reg_write   = 1'b1;
      bus.reg_addr    = 16'h0204;
      bus.reg_wdata   = 16'h0001;
      tick();
      chk("overlap_rst", 32'(sys_rst), 32'd3);
      chk("overlap_ack", 32'(bus.reg_ack), 32'd1);
      bus.reg_request = 1'b0;
      bus.reg_write   = 1'b0;
      idle(4);
      chk("overlap_after", 32'(sys_rst), 32'd1);

      // Reset mid-pulse aborts at once
      access(1'b1, 16'h0205, 1'b0, 16'h0002, e, r);
      rst = 1'b1;
      #1;
      model_reset();
      chk("midrst_sys_rst", 32'(sys_rst), 32'd0);
      chk("midrst_busy", 32'(rst_busy), 32'd0);
      chk("midrst_stall", 32'(cpu_stall), 32'd0);
      tick();
      rst = 1'b0;
      access(1'b0, 16'h0205, 1'b0, 16'h0000, e, r);
      chk("midrst_count", 32'(r), 32'd0);

      // Request held across reset gets no ack
      bus.reg_request = 1'b1;
      bus.reg_addr    = 16'h0200;
      rst             = 1'b1;
      tick();
      chk("abort_ack", 32'(bus.reg_ack), 32'd0);
      bus.reg_request = 1'b0;
      rst             = 1'b0;
      idle(1);

      // Random traffic against the model
      for (int i = 0; i < 300; i++) begin
         access(1'($urandom_range(0, 1)), 16'h01FE + 16'($urandom_range(0, 10)),
                ($urandom_range(0, 7) == 0), 16'($urandom), e, r);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/osd_scm_ctrl.md
# osd_scm_ctrl

Parametrised subnet control module: serves the read-only system identification registers (vendor, device, module count, maximum packet length) and adds host-controlled system reset and CPU stall. Sits behind the debug module's status/control register interface and answers register accesses in the 0x200–0x207 range. Drives per-domain reset outputs, either held or as timed pulses, and a global CPU stall line into the SoC.

## Interface
- SYSTEM_VENDOR, 16'h0: value returned at 0x200
- SYSTEM_DEVICE, 16'h0: value returned at 0x201
- NUM_MOD, 0: value returned at 0x202
- MAX_PKT_LEN, 0: value returned at 0x203
- NUM_RST_DOMAINS, 2: number of reset outputs, legal 1..16
- RST_PULSE_LEN, 16: pulse length in cycles, legal 1..65535
- CPU_STALL_INIT, 0: reset value of cpu_stall
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- reg_request  in  1  access request, held until reg_ack
- reg_write  in  1  1 = write, 0 = read
- reg_addr  in  16  register address
- reg_size  in  1  0 = 16-bit access; 1 = 32-bit access, not supported
- reg_wdata  in  16  write data
- reg_ack  out  1  single-cycle access completion
- reg_err  out  1  error flag, valid with reg_ack
- reg_rdata  out  16  read data, valid with reg_ack
- sys_rst  out  NUM_RST_DOMAINS  per-domain reset, active-high
- cpu_stall  out  1  global CPU stall
- rst_busy  out  1  reset pulse in progress

## Operation
- Register map:
  - 0x200 VENDOR, RO.
  - 0x201 DEVICE, RO.
  - 0x202 NUM_MOD, RO.
  - 0x203 MAX_PKT_LEN, RO.
  - 0x204 SYSRST_HOLD, RW. Bits [NUM_RST_DOMAINS-1:0] form a level hold mask; upper write bits are ignored and read as 0.
  - 0x205 SYSRST_PULSE. A write launches a pulse on the masked domains. A read returns the remaining pulse count.
  - 0x206 CPU_STALL, RW. Bit 0 only.
  - 0x207 STATUS, RO. Bit 0 = rst_busy; bits [15:8] = NUM_RST_DOMAINS.
- sys_rst = hold_mask | (pulse_mask & {NUM_RST_DOMAINS{rst_busy}}).
- Error cases: unmapped address, reg_size=1, a write to an RO register, or a write to 0x205 while rst_busy=1. Each error produces reg_ack=1 with reg_err=1 and no state change; reg_rdata is 0.
- A pulse write with a zero mask (after truncation) is acknowledged without error and starts no pulse.
- The pulse counter is 16-bit. It loads RST_PULSE_LEN, decrements once per cycle, and rst_busy = (count != 0).
- Writes to 0x204 or 0x206 during a pulse are legal and take effect immediately. The held and pulsed masks OR together.

## Timing
- Access FSM has two states:
  - IDLE samples reg_request. On request, it goes to RESP.
  - RESP drives reg_ack=1 for exactly one cycle and returns to IDLE.
- For a request sampled in cycle N, reg_ack/reg_err/reg_rdata are registered and asserted in cycle N+1. The next request is accepted no earlier than N+2.
- The requester drops reg_request in the cycle after reg_ack. A request still high in IDLE is a new access.
- reg_rdata is 0 whenever reg_ack=0, and is 0 for writes.
- Register writes take effect at the edge ending cycle N, so outputs change in cycle N+1, together with reg_ack.
- Pulse written in cycle N: sys_rst and rst_busy are high in cycles N+1 .. N+RST_PULSE_LEN. In cycle N+k the count reads RST_PULSE_LEN−k+1.
- A new pulse write is first accepted once rst_busy=0.
- Reset values (asynchronous, immediate): FSM=IDLE, reg_ack=0, reg_err=0, reg_rdata=0, sys_rst=0, hold_mask=0, pulse_mask=0, count=0, rst_busy=0, cpu_stall=CPU_STALL_INIT.
- Reset asserted mid-pulse or mid-access aborts immediately. No ack is issued for the aborted access.

## Test plan
- Read ID registers with SYSTEM_VENDOR=16'h1234, SYSTEM_DEVICE=16'h0042, NUM_MOD=5, MAX_PKT_LEN=12. Reads of 0x200..0x203 return 0x1234, 0x0042, 5 and 12, each with reg_ack one cycle after the request and reg_err=0.
- Error cases:
  - A read of 0x1FF returns reg_err=1 and reg_rdata=0.
  - A write of 0x0000 to 0x200 returns reg_err=1 and VENDOR is unchanged.
  - A read of 0x200 with reg_size=1 returns reg_err=1.
- Held reset with NUM_RST_DOMAINS=2:
  - Write 0xFFFF to 0x204. sys_rst=2'b11 from the ack cycle; readback is 0x0003.
  - Write 0x0000 to 0x204. sys_rst=2'b00.
- Pulse with RST_PULSE_LEN=4:
  - Write 0x0002 to 0x205 at cycle N. sys_rst=2'b10 and rst_busy=1 for cycles N+1..N+4, then 0.
  - A read of 0x205 at N+2 returns a count of 2 or lower, consistent with the counting formula.
  - A second pulse write at N+2 returns reg_err=1 and the pulse length is unchanged.
- Stall and overlap:
  - Write 1 to 0x206. cpu_stall=1; a read of 0x207 during a pulse returns bit0=1, bits[15:8]=2.
  - Write 0x0001 to 0x204 mid-pulse. sys_rst=2'b11.
- Reset mid-pulse: assert rst at N+2 of a pulse. sys_rst, rst_busy and count go to 0 immediately, and cpu_stall returns to CPU_STALL_INIT.
